// File: rtl/ap_ctrl_perf_monitor.sv
// ============================================================================
// ap_ctrl_perf_monitor -- per-channel ap_ctrl transaction count/latency stats
// Revision: 1.0
// ============================================================================
`default_nettype none

module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] sat
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAT_ONE = CNT_W'(1);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_all, last_all, min_all, max_all;
  logic [CNT_W-1:0]             rd_mux;

  // ap_ready carries no information this monitor needs.
  logic unused_ready;
  assign unused_ready = ^ap_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] lat, lat_nxt, lat_inc, commit_lat;
    logic [CNT_W-1:0] cnt, last, min_lat, max_lat;
    logic             lat_ovf, lat_sat, commit, sat_q;

    always_comb begin
      lat_ovf    = &lat;
      lat_inc    = lat_ovf ? lat : lat + LAT_ONE;
      state_nxt  = state;
      lat_nxt    = lat;
      commit_lat = lat;
      commit     = 1'b0;
      lat_sat    = 1'b0;
      case (state)
        IDLE: begin
          if (ap_start[i]) begin
            lat_nxt    = LAT_ONE;
            commit_lat = LAT_ONE;
            if (!ap_done[i])         state_nxt = RUN;
            else if (ap_continue[i]) commit    = 1'b1;
            else                     state_nxt = HOLD;
          end
        end
        RUN: begin
          lat_nxt    = lat_inc;
          lat_sat    = lat_ovf;
          commit_lat = lat_inc;
          if (ap_done[i]) begin
            if (ap_continue[i]) begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (ap_continue[i]) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (commit) lat_nxt = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset)       state <= IDLE;
      else if (clear)  state <= IDLE;
      else if (enable) state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        lat     <= '0;
        cnt     <= '0;
        last    <= '0;
        min_lat <= '1;
        max_lat <= '0;
        sat_q   <= 1'b0;
      end else if (clear) begin
        lat     <= '0;
        cnt     <= '0;
        last    <= '0;
        min_lat <= '1;
        max_lat <= '0;
        sat_q   <= 1'b0;
      end else if (enable) begin
        lat <= lat_nxt;
        if (lat_sat) sat_q <= 1'b1;
        if (commit) begin
          if (&cnt) sat_q <= 1'b1;
          else      cnt   <= cnt + LAT_ONE;
          last <= commit_lat;
          if (commit_lat < min_lat) min_lat <= commit_lat;
          if (commit_lat > max_lat) max_lat <= commit_lat;
        end
      end
    end

    assign busy[i]     = (state != IDLE);
    assign sat[i]      = sat_q;
    assign cnt_all[i]  = cnt;
    assign last_all[i] = last;
    assign min_all[i]  = min_lat;
    assign max_all[i]  = max_lat;
  end

  // Channels outside NUM_CH match no index and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        case (rd_sel)
          2'd0:    rd_mux = cnt_all[c];
          2'd1:    rd_mux = last_all[c];
          2'd2:    rd_mux = min_all[c];
          default: rd_mux = max_all[c];
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ap_ctrl_perf_monitor.sv
// ============================================================================
// tb_ap_ctrl_perf_monitor -- directed self-checking bench (NUM_CH=5, CNT_W=8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ap_ctrl_perf_monitor;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              clear;
  logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic              rd_en;
  logic [CH_W-1:0]   rd_ch;
  logic [1:0]        rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy, sat;

  int total = 0;
  int bad   = 0;

  ap_ctrl_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .sat(sat)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input int ch, input int sel, output logic v,
                         output logic [CNT_W-1:0] d, output logic v_after);
    rd_en  = 1'b1;
    rd_ch  = 3'(ch);
    rd_sel = 2'(sel);
    tick();
    v      = rd_valid;
    d      = rd_data;
    rd_en  = 1'b0;
    tick();
    v_after = rd_valid;
  endtask

  // s = {count, last, min, max}; ok = every read valid for exactly one cycle
  task automatic read_stats(input int ch, output logic [31:0] s, output logic ok);
    logic v, va;
    logic [CNT_W-1:0] d;
    ok = 1'b1;
    s  = '0;
    for (int k = 0; k < 4; k++) begin
      do_read(ch, k, v, d, va);
      s[31-8*k -: 8] = d;
      ok = ok & v & ~va;
    end
  endtask

  task automatic run_txn(input int ch, input int lat);
    ap_start[ch] = 1'b1;
    if (lat == 1) ap_done[ch] = 1'b1;
    tick();
    ap_start[ch] = 1'b0;
    ap_done[ch]  = 1'b0;
    if (lat > 1) begin
      repeat (lat - 2) tick();
      ap_done[ch] = 1'b1;
      tick();
      ap_done[ch] = 1'b0;
    end
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] s;
    logic ok;
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    rd_en = 1'b0; rd_ch = '0; rd_sel = '0;
    #1;
    total++;
    if ({rd_valid, rd_data, busy, sat} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b data=%0d busy=%b sat=%b want all 0",
               rd_valid, rd_data, busy, sat);
    end
    tick(); tick();
    reset = 1'b0;
    read_stats(0, s, ok);
    total++;
    if (s !== {8'd0, 8'd0, 8'd255, 8'd0}) begin
      bad++;
      $display("FAIL reset_stats: got %h want 0000ff00", s);
    end
  endtask

  task automatic test_basic();
    logic [31:0] s;
    logic ok;
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b1) begin
      bad++; $display("FAIL basic_busy_run: got %b want 1", busy[0]);
    end
    repeat (3) tick();
    ap_done[0] = 1'b1;
    tick();
    ap_done[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b0) begin
      bad++; $display("FAIL basic_busy_idle: got %b want 0", busy[0]);
    end
    read_stats(0, s, ok);
    total++;
    if (s !== {8'd1, 8'd5, 8'd5, 8'd5}) begin
      bad++; $display("FAIL basic_stats: got %h want 01050505", s);
    end
  endtask

  task automatic test_multi();
    logic [31:0] s;
    logic ok;
    run_txn(1, 3);
    run_txn(1, 7);
    run_txn(1, 2);
    read_stats(1, s, ok);
    total++;
    if (s !== {8'd3, 8'd2, 8'd2, 8'd7}) begin
      bad++; $display("FAIL multi_stats: got %h want 03020207", s);
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL multi_rd_valid: got ok=%b want 1", ok);
    end
  endtask

  task automatic test_hold();
    logic [31:0] s;
    logic ok, all_busy;
    ap_start[2] = 1'b1;
    tick();
    ap_start[2] = 1'b0;
    tick();
    ap_done[2] = 1'b1;
    ap_continue[2] = 1'b0;
    tick();
    ap_done[2] = 1'b0;
    all_busy = busy[2];
    for (int k = 0; k < 3; k++) begin
      tick();
      all_busy = all_busy & busy[2];
    end
    total++;
    if (all_busy !== 1'b1) begin
      bad++; $display("FAIL hold_busy: got %b want 1", all_busy);
    end
    ap_continue[2] = 1'b1;
    tick();
    total++;
    if (busy[2] !== 1'b0) begin
      bad++; $display("FAIL hold_release_busy: got %b want 0", busy[2]);
    end
    read_stats(2, s, ok);
    total++;
    if (s !== {8'd1, 8'd3, 8'd3, 8'd3}) begin
      bad++; $display("FAIL hold_stats: got %h want 01030303", s);
    end
  endtask

  task automatic test_single_cycle();
    logic [31:0] s;
    logic ok;
    run_txn(3, 1);
    read_stats(3, s, ok);
    total++;
    if (s !== {8'd1, 8'd1, 8'd1, 8'd1}) begin
      bad++; $display("FAIL single_stats: got %h want 01010101", s);
    end
    total++;
    if (sat[3] !== 1'b0) begin
      bad++; $display("FAIL single_sat: got %b want 0", sat[3]);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] s;
    logic ok;
    run_txn(3, 300);
    total++;
    if (sat !== 5'b01000) begin
      bad++; $display("FAIL sat_flag: got %b want 01000", sat);
    end
    read_stats(3, s, ok);
    total++;
    if (s !== {8'd2, 8'd255, 8'd1, 8'd255}) begin
      bad++; $display("FAIL sat_stats: got %h want 02ff01ff", s);
    end
  endtask

  task automatic test_enable();
    logic [31:0] s;
    logic ok, all_busy, v, va;
    logic [CNT_W-1:0] d;
    ap_start[4] = 1'b1;
    tick();
    ap_start[4] = 1'b0;
    tick();
    enable = 1'b0;
    all_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      all_busy = all_busy & busy[4];
    end
    total++;
    if (all_busy !== 1'b1) begin
      bad++; $display("FAIL enable_busy_frozen: got %b want 1", all_busy);
    end
    enable = 1'b1;
    repeat (3) tick();
    ap_done[4] = 1'b1;
    tick();
    ap_done[4] = 1'b0;
    read_stats(4, s, ok);
    total++;
    if (s !== {8'd1, 8'd6, 8'd6, 8'd6}) begin
      bad++; $display("FAIL enable_stats: got %h want 01060606", s);
    end
    do_read(NUM_CH, 0, v, d, va);
    total++;
    if ({v, d, va} !== {1'b1, 8'd0, 1'b0}) begin
      bad++; $display("FAIL oob_read: got v=%b d=%0d after=%b want v=1 d=0 after=0", v, d, va);
    end
  endtask

  task automatic test_reset_clear();
    logic [31:0] s;
    logic ok;
    ap_start[0] = 1'b1;
    tick();
    ap_start[0] = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    #1;
    total++;
    if ({busy, sat, rd_valid} !== '0) begin
      bad++; $display("FAIL async_reset: got busy=%b sat=%b valid=%b want 0", busy, sat, rd_valid);
    end
    tick();
    reset = 1'b0;
    repeat (3) tick();
    read_stats(0, s, ok);
    total++;
    if (s !== {8'd0, 8'd0, 8'd255, 8'd0} || busy[0] !== 1'b0) begin
      bad++; $display("FAIL reset_midrun: got %h busy=%b want 0000ff00 busy=0", s, busy[0]);
    end
    run_txn(1, 2);
    ap_start[1] = 1'b1;
    tick();
    ap_start[1] = 1'b0;
    ap_done[1] = 1'b1;
    clear = 1'b1;
    tick();
    ap_done[1] = 1'b0;
    clear = 1'b0;
    read_stats(1, s, ok);
    total++;
    if (s !== {8'd0, 8'd0, 8'd255, 8'd0} || busy[1] !== 1'b0) begin
      bad++; $display("FAIL clear_commit: got %h busy=%b want 0000ff00 busy=0", s, busy[1]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_hold();
    test_single_cycle();
    test_saturation();
    test_enable();
    test_reset_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
